// File: rtl/conv33_window_gen.sv
// Streaming 3x3 sliding-window generator: buffers two rows of a raster pixel stream
// and emits every fully populated 3x3 window (valid convolution, no padding).
module conv33_window_gen #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned IMG_W      = 28,
    parameter int unsigned IMG_H      = 28
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_0_0,
    output logic [DATA_WIDTH-1:0] out_0_1,
    output logic [DATA_WIDTH-1:0] out_0_2,
    output logic [DATA_WIDTH-1:0] out_1_0,
    output logic [DATA_WIDTH-1:0] out_1_1,
    output logic [DATA_WIDTH-1:0] out_1_2,
    output logic [DATA_WIDTH-1:0] out_2_0,
    output logic [DATA_WIDTH-1:0] out_2_1,
    output logic [DATA_WIDTH-1:0] out_2_2,
    output logic                  frame_done,
    output logic                  busy
);

    localparam int unsigned COL_W = $clog2(IMG_W);
    localparam int unsigned ROW_W = $clog2(IMG_H);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] MIN_COL  = COL_W'(2);
    localparam logic [ROW_W-1:0] MIN_ROW  = ROW_W'(2);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [COL_W-1:0]      col_q, col_d;
    logic [ROW_W-1:0]      row_q, row_d;
    logic                  in_ready_q, in_ready_d;
    logic                  out_valid_q, out_valid_d;
    logic                  frame_done_q, frame_done_d;
    logic                  busy_q, busy_d;
    logic [DATA_WIDTH-1:0] win_q [3][3];
    logic [DATA_WIDTH-1:0] win_d [3][3];

    // Two row-deep line buffers: lb0 holds row-2, lb1 holds row-1 at each column.
    logic [DATA_WIDTH-1:0] lb0_q [IMG_W];
    logic [DATA_WIDTH-1:0] lb1_q [IMG_W];

    logic accept_c;
    assign accept_c = in_valid && in_ready_q;

    // Next-state, counters, window shift and registered-output next values.
    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        out_valid_d  = 1'b0;
        win_d        = win_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    col_d   = '0;
                    row_d   = '0;
                end
            end
            ST_RUN: begin
                if (accept_c) begin
                    for (int r = 0; r < 3; r++) begin
                        win_d[r][0] = win_q[r][1];
                        win_d[r][1] = win_q[r][2];
                    end
                    win_d[0][2] = lb0_q[col_q];
                    win_d[1][2] = lb1_q[col_q];
                    win_d[2][2] = in_data;
                    out_valid_d = (row_q >= MIN_ROW) && (col_q >= MIN_COL);
                    if (col_q == LAST_COL) begin
                        col_d = '0;
                        if (row_q == LAST_ROW) begin
                            row_d   = '0;
                            state_d = ST_DONE;
                        end else begin
                            row_d = row_q + ROW_W'(1);
                        end
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Status flags are registered images of the state being entered.
        in_ready_d   = (state_d == ST_RUN);
        busy_d       = (state_d != ST_IDLE);
        frame_done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            col_q        <= '0;
            row_q        <= '0;
            in_ready_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
            win_q        <= win_d;
        end
    end

    // Line-buffer RAM: contents survive reset; stale rows are never emitted.
    always_ff @(posedge clk) begin
        if (accept_c) begin
            lb0_q[col_q] <= lb1_q[col_q];
            lb1_q[col_q] <= in_data;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign frame_done = frame_done_q;
    assign busy       = busy_q;
    assign out_0_0    = win_q[0][0];
    assign out_0_1    = win_q[0][1];
    assign out_0_2    = win_q[0][2];
    assign out_1_0    = win_q[1][0];
    assign out_1_1    = win_q[1][1];
    assign out_1_2    = win_q[1][2];
    assign out_2_0    = win_q[2][0];
    assign out_2_1    = win_q[2][1];
    assign out_2_2    = win_q[2][2];

endmodule

// File: tb/tb_conv33_window_gen.sv
// Directed bench for conv33_window_gen: a 4x4 instance and a 5x3 instance checked
// against hand-computed window tables.
module tb_conv33_window_gen;

    typedef struct {
        int          ord;
        logic [71:0] w;
        logic        done;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       a_start, a_valid;
    logic [7:0] a_data;
    logic       a_ready, a_ov, a_done, a_busy;
    logic [7:0] a00, a01, a02, a10, a11, a12, a20, a21, a22;

    logic       b_start, b_valid;
    logic [7:0] b_data;
    logic       b_ready, b_ov, b_done, b_busy;
    logic [7:0] b00, b01, b02, b10, b11, b12, b20, b21, b22;

    conv33_window_gen #(.DATA_WIDTH(8), .IMG_W(4), .IMG_H(4)) dut (
        .clk(clk), .rst(rst), .start(a_start), .in_valid(a_valid), .in_data(a_data),
        .in_ready(a_ready), .out_valid(a_ov),
        .out_0_0(a00), .out_0_1(a01), .out_0_2(a02),
        .out_1_0(a10), .out_1_1(a11), .out_1_2(a12),
        .out_2_0(a20), .out_2_1(a21), .out_2_2(a22),
        .frame_done(a_done), .busy(a_busy)
    );

    conv33_window_gen #(.DATA_WIDTH(8), .IMG_W(5), .IMG_H(3)) dut5 (
        .clk(clk), .rst(rst), .start(b_start), .in_valid(b_valid), .in_data(b_data),
        .in_ready(b_ready), .out_valid(b_ov),
        .out_0_0(b00), .out_0_1(b01), .out_0_2(b02),
        .out_1_0(b10), .out_1_1(b11), .out_1_2(b12),
        .out_2_0(b20), .out_2_1(b21), .out_2_2(b22),
        .frame_done(b_done), .busy(b_busy)
    );

    int checks = 0;
    int errors = 0;

    logic        o_ready, o_ov, o_done, o_busy;
    logic [71:0] o_win;
    vec_t        cap_q[$];
    vec_t        exp44[4];
    vec_t        exp53[3];

    function automatic logic [71:0] pk(input int v0, input int v1, input int v2,
                                       input int v3, input int v4, input int v5,
                                       input int v6, input int v7, input int v8);
        return {8'(v0), 8'(v1), 8'(v2), 8'(v3), 8'(v4), 8'(v5), 8'(v6), 8'(v7), 8'(v8)};
    endfunction

    function automatic logic [71:0] add_base(input logic [71:0] w, input int base);
        logic [71:0] r;
        for (int i = 0; i < 9; i++) r[i*8 +: 8] = w[i*8 +: 8] + 8'(base);
        return r;
    endfunction

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic sample(input int sel);
        if (sel == 0) begin
            o_ready = a_ready; o_ov = a_ov; o_done = a_done; o_busy = a_busy;
            o_win   = {a00, a01, a02, a10, a11, a12, a20, a21, a22};
        end else begin
            o_ready = b_ready; o_ov = b_ov; o_done = b_done; o_busy = b_busy;
            o_win   = {b00, b01, b02, b10, b11, b12, b20, b21, b22};
        end
    endtask

    // One clock: drive the selected instance, keep the other idle, sample 1 unit after the edge.
    task automatic cycle(input int sel, input logic st, input logic v, input logic [7:0] d);
        a_start = (sel == 0) && st; a_valid = (sel == 0) && v; a_data = d;
        b_start = (sel == 1) && st; b_valid = (sel == 1) && v; b_data = d;
        @(posedge clk);
        #1;
        sample(sel);
    endtask

    // Drive one frame; toggle inserts idle cycles, start_mid pulses start during them.
    task automatic run_frame(input int sel, input int n_pix, input int base,
                             input bit toggle, input bit start_mid);
        int  p;
        int  k;
        bit  v;
        bit  acc;
        bit  prev_ready;
        cycle(sel, 1'b1, 1'b0, 8'h00);
        chk("start_ready", 72'(o_ready), 72'd1);
        chk("start_busy", 72'(o_busy), 72'd1);
        p = 0;
        k = 0;
        while (p < n_pix) begin
            if (k > 200) begin
                chk("frame_timeout", 72'(p), 72'(n_pix));
                break;
            end
            v = toggle ? (k % 2 == 0) : 1'b1;
            prev_ready = o_ready;
            cycle(sel, start_mid && !v, v, 8'(base + p));
            acc = v && prev_ready;
            if (o_ov) cap_q.push_back('{acc ? p : -1, o_win, o_done});
            if (!acc) chk("ov_without_accept", 72'(o_ov), 72'd0);
            if (acc) p++;
            k++;
        end
        chk("done_cycle_ready", 72'(o_ready), 72'd0);
        cycle(sel, 1'b0, 1'b0, 8'h00);
        chk("after_done_flags", {69'd0, o_ready, o_busy, o_done}, 72'd0);
        chk("after_done_ov", 72'(o_ov), 72'd0);
    endtask

    task automatic compare_frame(input int sel, input int base);
        int   n;
        vec_t e;
        n = (sel == 0) ? 4 : 3;
        chk("window_count", 72'(cap_q.size()), 72'(n));
        for (int i = 0; i < n && i < cap_q.size(); i++) begin
            e = (sel == 0) ? exp44[i] : exp53[i];
            chk($sformatf("win%0d_after_pixel", i), 72'(cap_q[i].ord), 72'(e.ord));
            chk($sformatf("win%0d_taps", i), cap_q[i].w, add_base(e.w, base));
            chk($sformatf("win%0d_frame_done", i), 72'(cap_q[i].done), 72'(e.done));
        end
        cap_q.delete();
    endtask

    initial begin
        exp44[0] = '{10, pk(0, 1, 2, 4, 5, 6, 8, 9, 10), 1'b0};
        exp44[1] = '{11, pk(1, 2, 3, 5, 6, 7, 9, 10, 11), 1'b0};
        exp44[2] = '{14, pk(4, 5, 6, 8, 9, 10, 12, 13, 14), 1'b0};
        exp44[3] = '{15, pk(5, 6, 7, 9, 10, 11, 13, 14, 15), 1'b1};
        exp53[0] = '{12, pk(0, 1, 2, 5, 6, 7, 10, 11, 12), 1'b0};
        exp53[1] = '{13, pk(1, 2, 3, 6, 7, 8, 11, 12, 13), 1'b0};
        exp53[2] = '{14, pk(2, 3, 4, 7, 8, 9, 12, 13, 14), 1'b1};

        a_start = 0; a_valid = 0; a_data = 0;
        b_start = 0; b_valid = 0; b_data = 0;
        rst = 1'b1;
        #12;
        sample(0);
        chk("reset_flags_4x4", {68'd0, o_ready, o_ov, o_done, o_busy}, 72'd0);
        chk("reset_win_4x4", o_win, 72'd0);
        sample(1);
        chk("reset_flags_5x3", {68'd0, o_ready, o_ov, o_done, o_busy}, 72'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Frame A then frame B started in the first IDLE cycle after DONE.
        run_frame(0, 16, 0, 1'b0, 1'b0);
        compare_frame(0, 0);
        run_frame(0, 16, 100, 1'b0, 1'b0);
        compare_frame(0, 100);

        // Gapped stream with stray start pulses in RUN.
        run_frame(0, 16, 0, 1'b1, 1'b1);
        compare_frame(0, 0);

        // in_valid held high in IDLE must not be accepted.
        for (int i = 0; i < 3; i++) begin
            cycle(0, 1'b0, 1'b1, 8'hAA);
            chk("idle_valid_flags", {69'd0, o_ready, o_busy, o_ov}, 72'd0);
        end

        // Abort a frame after 9 pixels with an asynchronous reset.
        cycle(0, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 9; i++) cycle(0, 1'b0, 1'b1, 8'(200 + i));
        a_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        sample(0);
        chk("midframe_reset_flags", {68'd0, o_ready, o_ov, o_done, o_busy}, 72'd0);
        chk("midframe_reset_win", o_win, 72'd0);
        @(posedge clk);
        #1;
        sample(0);
        chk("reset_held_win", o_win, 72'd0);
        rst = 1'b0;
        run_frame(0, 16, 0, 1'b0, 1'b0);
        compare_frame(0, 0);

        // Non-square 5x3 frame.
        run_frame(1, 15, 0, 1'b0, 1'b0);
        compare_frame(1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
